// File: rtl/divide_arbiter.sv
// Round-robin arbiter sharing one multicycle fixed-point divider between N_REQ requesters.
// One divide in flight; divide-by-zero answered locally, divider hangs trapped by a watchdog.
module divide_arbiter #(
  parameter int N_REQ   = 4,
  parameter int D_WIDTH = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*D_WIDTH-1:0]   req_dividend,
  input  logic [N_REQ*D_WIDTH-1:0]   req_divisor,
  output logic [N_REQ-1:0]           resp_valid,
  input  logic [N_REQ-1:0]           resp_ready,
  output logic [D_WIDTH-1:0]         resp_quotient,
  output logic                       resp_err,
  output logic                       div_valid_in,
  output logic [D_WIDTH-1:0]         div_dividend,
  output logic [D_WIDTH-1:0]         div_divisor,
  input  logic                       div_valid_out,
  input  logic [D_WIDTH-1:0]         div_quotient
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]    WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [D_WIDTH-1:0] SAT_MAX = {1'b0, {(D_WIDTH-1){1'b1}}};
  localparam logic [D_WIDTH-1:0] SAT_MIN = {1'b1, {(D_WIDTH-1){1'b0}}};
  localparam logic [N_REQ-1:0]   ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t               state_reg, state_next;
  logic [PTR_W-1:0]     rr_ptr_reg;
  logic [PTR_W-1:0]     owner_reg;
  logic [PTR_W-1:0]     grant_idx;
  logic                 grant_found;
  logic                 accept;
  logic                 div_by_zero;
  logic                 timeout_hit;
  logic [WD_W-1:0]      watchdog_reg;
  logic [N_REQ-1:0]     resp_valid_reg;
  logic [D_WIDTH-1:0]   resp_quotient_reg;
  logic                 resp_err_reg;
  logic                 div_valid_in_reg;
  logic [D_WIDTH-1:0]   div_dividend_reg;
  logic [D_WIDTH-1:0]   div_divisor_reg;
  logic [D_WIDTH-1:0]   dividend_arr [N_REQ];
  logic [D_WIDTH-1:0]   divisor_arr  [N_REQ];
  logic [D_WIDTH-1:0]   sel_dividend;
  logic [D_WIDTH-1:0]   sel_divisor;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign dividend_arr[gi] = req_dividend[gi*D_WIDTH +: D_WIDTH];
      assign divisor_arr[gi]  = req_divisor[gi*D_WIDTH +: D_WIDTH];
    end
  endgenerate

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return PTR_W'(s);
  endfunction

  // First requester at or after rr_ptr, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!grant_found && req_valid[wrap_add(rr_ptr_reg, k)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_add(rr_ptr_reg, k);
      end
    end
  end

  assign sel_dividend = dividend_arr[grant_idx];
  assign sel_divisor  = divisor_arr[grant_idx];
  assign div_by_zero  = (sel_divisor == '0);
  assign timeout_hit  = (watchdog_reg == WD_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = '0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant_found && !reset) begin
          accept     = 1'b1;
          req_ready  = ONE_HOT0 << grant_idx;
          state_next = div_by_zero ? RESP : ISSUE;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT:  if (div_valid_out || timeout_hit) state_next = RESP;
      RESP:  if (resp_ready[owner_reg]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr_reg        <= '0;
      owner_reg         <= '0;
      watchdog_reg      <= '0;
      resp_valid_reg    <= '0;
      resp_quotient_reg <= '0;
      resp_err_reg      <= 1'b0;
      div_valid_in_reg  <= 1'b0;
      div_dividend_reg  <= '0;
      div_divisor_reg   <= '0;
    end else begin
      div_valid_in_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            owner_reg  <= grant_idx;
            rr_ptr_reg <= wrap_add(grant_idx, 1);
            if (div_by_zero) begin
              resp_quotient_reg <= sel_dividend[D_WIDTH-1] ? SAT_MIN : SAT_MAX;
              resp_err_reg      <= 1'b1;
              resp_valid_reg    <= ONE_HOT0 << grant_idx;
            end else begin
              div_dividend_reg <= sel_dividend;
              div_divisor_reg  <= sel_divisor;
              div_valid_in_reg <= 1'b1;
            end
          end
        end
        ISSUE: watchdog_reg <= '0;
        WAIT: begin
          // A real result beats a timeout landing in the same cycle.
          if (div_valid_out) begin
            resp_quotient_reg <= div_quotient;
            resp_err_reg      <= 1'b0;
            resp_valid_reg    <= ONE_HOT0 << owner_reg;
          end else if (timeout_hit) begin
            resp_quotient_reg <= '0;
            resp_err_reg      <= 1'b1;
            resp_valid_reg    <= ONE_HOT0 << owner_reg;
          end else begin
            watchdog_reg <= watchdog_reg + 1'b1;
          end
        end
        RESP: if (resp_ready[owner_reg]) resp_valid_reg <= '0;
        default: ;
      endcase
    end
  end

  assign resp_valid    = resp_valid_reg;
  assign resp_quotient = resp_quotient_reg;
  assign resp_err      = resp_err_reg;
  assign div_valid_in  = div_valid_in_reg;
  assign div_dividend  = div_dividend_reg;
  assign div_divisor   = div_divisor_reg;

endmodule
